// File: rtl/sram_pkg.sv
// Shared definitions for the single-port SRAM controller: FSM encoding,
// legal read latencies and an elaboration-time clog2.
package sram_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sp_sram_array.sv
// Plain single-port storage: synchronous write, registered read, no reset.
module sp_sram_array
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_DEPTH = 33,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                         iClk_12M,
  input  logic                         iWe,
  input  logic                         iRe,
  input  logic [ADDR_WIDTH-1:0]        iAddr,
  input  logic signed [DATA_WIDTH-1:0] iWrDt,
  output logic signed [DATA_WIDTH-1:0] oRdDt
);

  logic signed [DATA_WIDTH-1:0] mem [ADDR_DEPTH];

  always_ff @(posedge iClk_12M) begin
    if (iWe) mem[iAddr] <= iWrDt;
    if (iRe) oRdDt <= mem[iAddr];
  end

endmodule

// File: rtl/sp_sram_ctrl.sv
// Single-port SRAM with sequential self-clear, address-range checking and a
// 1- or 2-cycle read pipeline with valid strobe.
module sp_sram_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_DEPTH = 33,
  parameter int ADDR_WIDTH = 6,
  parameter int RD_LAT     = 1,
  parameter logic signed [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                         iClk_12M,
  input  logic                         iRst,
  input  logic                         iClrReq,
  input  logic                         iCsnRam,
  input  logic                         iWrnRam,
  input  logic [ADDR_WIDTH-1:0]        iAddrRam,
  input  logic signed [DATA_WIDTH-1:0] iWrDtRam,
  output logic signed [DATA_WIDTH-1:0] oRdDtRam,
  output logic                         oRdVld,
  output logic                         oBusy,
  output logic                         oAddrErr
);

  if (ADDR_WIDTH < clog2(ADDR_DEPTH) || RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : gBadParam
    $error("sp_sram_ctrl: illegal ADDR_WIDTH/ADDR_DEPTH/RD_LAT combination");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(ADDR_DEPTH);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clrCnt;
  logic clrNow, clrActive, userAcc, inRange;
  logic userWr, userRd, wrErr, rdErr;
  logic arrWe;
  logic [ADDR_WIDTH-1:0]        arrAddr;
  logic signed [DATA_WIDTH-1:0] arrWrDt;
  logic signed [DATA_WIDTH-1:0] arrRdDt_p1;
  logic rdVld_p1, rdErr_p1, wrErr_p1, rdErrOut;

  // A clear request restarts at address 0 in the request cycle itself and
  // takes the port over from any user access in that cycle.
  always_comb begin
    clrNow    = iClrReq && !iRst;
    clrActive = !iRst && (clrNow || state == ST_INIT);
    userAcc   = !iRst && !iClrReq && (state == ST_RUN) && !iCsnRam;
    inRange   = {1'b0, iAddrRam} < DEPTH_EXT;
    userWr    = userAcc && !iWrnRam && inRange;
    userRd    = userAcc &&  iWrnRam && inRange;
    wrErr     = userAcc && !iWrnRam && !inRange;
    rdErr     = userAcc &&  iWrnRam && !inRange;
    arrWe     = clrActive || userWr;
    arrAddr   = clrActive ? (clrNow ? '0 : clrCnt) : iAddrRam;
    arrWrDt   = clrActive ? INIT_VAL : iWrDtRam;
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state  <= ST_INIT;
      clrCnt <= '0;
    end else if (clrNow) begin
      state  <= (LAST_ADDR == '0) ? ST_RUN : ST_INIT;
      clrCnt <= (LAST_ADDR == '0) ? '0 : ADDR_WIDTH'(1);
    end else if (state == ST_INIT) begin
      if (clrCnt == LAST_ADDR) begin
        state  <= ST_RUN;
        clrCnt <= '0;
      end else begin
        clrCnt <= clrCnt + 1'b1;
      end
    end
  end

  assign oBusy = (state == ST_INIT);

  sp_sram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_DEPTH(ADDR_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) uArray (
    .iClk_12M(iClk_12M),
    .iWe     (arrWe),
    .iRe     (userRd),
    .iAddr   (arrAddr),
    .iWrDt   (arrWrDt),
    .oRdDt   (arrRdDt_p1)
  );

  // Stage p1: memory output register and its valid/error companions
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      rdVld_p1 <= 1'b0;
      rdErr_p1 <= 1'b0;
      wrErr_p1 <= 1'b0;
    end else begin
      rdVld_p1 <= userRd;
      rdErr_p1 <= rdErr;
      wrErr_p1 <= wrErr;
    end
  end

  if (RD_LAT == 1) begin : gLat1
    logic rdZero_p1;

    // The array itself has no reset, so a flag masks its output to 0 until
    // the first read after reset lands.
    always_ff @(posedge iClk_12M) begin
      if (iRst)        rdZero_p1 <= 1'b1;
      else if (userRd) rdZero_p1 <= 1'b0;
    end

    assign oRdDtRam = rdZero_p1 ? '0 : arrRdDt_p1;
    assign oRdVld   = rdVld_p1;
    assign rdErrOut = rdErr_p1;
  end else begin : gLat2
    logic                         rdVld_p2, rdErr_p2;
    logic signed [DATA_WIDTH-1:0] rdDt_p2;

    // Stage p2: output register; a clear request flushes the read in flight
    always_ff @(posedge iClk_12M) begin
      if (iRst) begin
        rdVld_p2 <= 1'b0;
        rdErr_p2 <= 1'b0;
        rdDt_p2  <= '0;
      end else begin
        rdVld_p2 <= rdVld_p1 && !iClrReq;
        rdErr_p2 <= rdErr_p1 && !iClrReq;
        if (rdVld_p1 && !iClrReq) rdDt_p2 <= arrRdDt_p1;
      end
    end

    assign oRdDtRam = rdDt_p2;
    assign oRdVld   = rdVld_p2;
    assign rdErrOut = rdErr_p2;
  end

  assign oAddrErr = wrErr_p1 || rdErrOut;

endmodule

// File: tb/tb_sp_sram_ctrl.sv
// Directed bench: two controllers (RD_LAT=1/INIT 0 and RD_LAT=2/INIT 0x00AA)
// driven by the same stimulus and checked against hand-derived values.
module tb_sp_sram_ctrl;

  logic               iClk_12M = 1'b0;
  logic               iRst, iClrReq, iCsnRam, iWrnRam;
  logic [5:0]         iAddrRam;
  logic signed [15:0] iWrDtRam;
  logic signed [15:0] rdDtA, rdDtB;
  logic vldA, vldB, busyA, busyB, errA, errB;

  int checks   = 0;
  int failures = 0;
  int nA, nB;

  always #5 iClk_12M = ~iClk_12M;

  sp_sram_ctrl #(.DATA_WIDTH(16), .ADDR_DEPTH(33), .ADDR_WIDTH(6), .RD_LAT(1),
                 .INIT_VAL(16'sh0000)) dutA (
    .iClk_12M(iClk_12M), .iRst(iRst), .iClrReq(iClrReq), .iCsnRam(iCsnRam),
    .iWrnRam(iWrnRam), .iAddrRam(iAddrRam), .iWrDtRam(iWrDtRam),
    .oRdDtRam(rdDtA), .oRdVld(vldA), .oBusy(busyA), .oAddrErr(errA));

  sp_sram_ctrl #(.DATA_WIDTH(16), .ADDR_DEPTH(33), .ADDR_WIDTH(6), .RD_LAT(2),
                 .INIT_VAL(16'sh00AA)) dutB (
    .iClk_12M(iClk_12M), .iRst(iRst), .iClrReq(iClrReq), .iCsnRam(iCsnRam),
    .iWrnRam(iWrnRam), .iAddrRam(iAddrRam), .iWrDtRam(iWrDtRam),
    .oRdDtRam(rdDtB), .oRdVld(vldB), .oBusy(busyB), .oAddrErr(errB));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge iClk_12M);
  endtask

  task automatic idle();
    iClrReq = 1'b0; iCsnRam = 1'b1; iWrnRam = 1'b1; iAddrRam = '0; iWrDtRam = '0;
  endtask

  task automatic drvWr(input logic [5:0] a, input logic [15:0] d);
    iCsnRam = 1'b0; iWrnRam = 1'b0; iAddrRam = a; iWrDtRam = d;
  endtask

  task automatic drvRd(input logic [5:0] a);
    iCsnRam = 1'b0; iWrnRam = 1'b1; iAddrRam = a;
  endtask

  // Counts busy cycles of each DUT from the current cycle; optional clear pulse.
  task automatic busyRun(input int clrAt, output int cntA, output int cntB);
    int c;
    c = 0; cntA = 0; cntB = 0;
    while ((busyA || busyB) && c < 200) begin
      if (busyA) cntA++;
      if (busyB) cntB++;
      iClrReq = (c == clrAt);
      tick();
      c++;
    end
    iClrReq = 1'b0;
  endtask

  task automatic rdChk(input string tag, input logic [5:0] a, input logic [15:0] eA, input logic [15:0] eB);
    drvRd(a); tick(); idle();
    chk({tag, ".vldA@1"}, vldA, 1'b1);
    chk({tag, ".dtA@1"}, rdDtA, eA);
    chk({tag, ".vldB@1"}, vldB, 1'b0);
    tick();
    chk({tag, ".vldA@2"}, vldA, 1'b0);
    chk({tag, ".dtA@2"}, rdDtA, eA);
    chk({tag, ".vldB@2"}, vldB, 1'b1);
    chk({tag, ".dtB@2"}, rdDtB, eB);
  endtask

  // Back-to-back reads of every address, one issued per cycle.
  task automatic rdAll(input string tag);
    for (int i = 0; i < 35; i++) begin
      if (i >= 1 && i <= 33) begin
        chk({tag, ".vldA"}, vldA, 1'b1);
        chk({tag, ".dtA"}, rdDtA, 16'h0000);
      end
      if (i >= 2) begin
        chk({tag, ".vldB"}, vldB, 1'b1);
        chk({tag, ".dtB"}, rdDtB, 16'h00AA);
      end
      if (i < 33) drvRd(i[5:0]);
      else idle();
      tick();
    end
    chk({tag, ".drainA"}, vldA, 1'b0);
    chk({tag, ".drainB"}, vldB, 1'b0);
  endtask

  initial begin
    idle();
    iRst = 1'b1;
    tick(); tick();
    chk("rst.dtA", rdDtA, 16'h0000);
    chk("rst.vldA", vldA, 1'b0);
    chk("rst.busyA", busyA, 1'b1);
    chk("rst.errA", errA, 1'b0);
    chk("rst.dtB", rdDtB, 16'h0000);
    chk("rst.vldB", vldB, 1'b0);
    chk("rst.busyB", busyB, 1'b1);
    chk("rst.errB", errB, 1'b0);

    iRst = 1'b0;
    busyRun(-1, nA, nB);
    chk("clr.busyCycA", nA[15:0], 16'd33);
    chk("clr.busyCycB", nB[15:0], 16'd33);
    rdAll("init");

    // Extreme signed values at both ends, write followed directly by read
    drvWr(6'd0, 16'h7FFF); tick();
    drvWr(6'd32, 16'h8000); tick();
    rdChk("rd32", 6'd32, 16'h8000, 16'h8000);
    rdChk("rd0", 6'd0, 16'h7FFF, 16'h7FFF);

    // Out-of-range write then read
    drvWr(6'd33, 16'h1234); tick();
    chk("oor.errA@1", errA, 1'b1);
    chk("oor.errB@1", errB, 1'b1);
    drvRd(6'd33); tick();
    chk("oor.errA@2", errA, 1'b1);
    chk("oor.errB@2", errB, 1'b0);
    chk("oor.vldA@2", vldA, 1'b0);
    idle(); tick();
    chk("oor.errA@3", errA, 1'b0);
    chk("oor.errB@3", errB, 1'b1);
    chk("oor.vldB@3", vldB, 1'b0);
    chk("oor.dtA", rdDtA, 16'h7FFF);
    chk("oor.dtB", rdDtB, 16'h7FFF);
    tick();
    chk("oor.errB@4", errB, 1'b0);
    rdChk("oor.keep32", 6'd32, 16'h8000, 16'h8000);
    rdChk("oor.keep1", 6'd1, 16'h0000, 16'h00AA);

    // Clear request while a read is in flight
    drvRd(6'd0); tick();
    chk("fclr.vldA", vldA, 1'b1);
    chk("fclr.dtA", rdDtA, 16'h7FFF);
    idle(); iClrReq = 1'b1; tick(); iClrReq = 1'b0;
    chk("fclr.vldB", vldB, 1'b0);
    chk("fclr.dtB", rdDtB, 16'h00AA);
    chk("fclr.holdA", rdDtA, 16'h7FFF);
    chk("fclr.busyA", busyA, 1'b1);
    busyRun(-1, nA, nB);
    chk("fclr.doneA", busyA, 1'b0);
    chk("fclr.doneB", busyB, 1'b0);
    rdChk("fclr.rd0", 6'd0, 16'h0000, 16'h00AA);

    // Reset while a read is in flight, then a restarted clear at cycle 10
    drvWr(6'd3, 16'h1111); tick();
    drvRd(6'd3); tick();
    chk("frst.vldA", vldA, 1'b1);
    chk("frst.dtA", rdDtA, 16'h1111);
    idle(); iRst = 1'b1; tick();
    chk("frst.vldB", vldB, 1'b0);
    chk("frst.dtB", rdDtB, 16'h0000);
    chk("frst.dtA", rdDtA, 16'h0000);
    chk("frst.busyA", busyA, 1'b1);
    iRst = 1'b0;
    busyRun(10, nA, nB);
    chk("reclr.busyCycA", nA[15:0], 16'd43);
    chk("reclr.busyCycB", nB[15:0], 16'd43);
    rdAll("reclr");

    // Clear request beats a simultaneous write
    drvWr(6'd5, 16'h5555); iClrReq = 1'b1; tick(); idle();
    busyRun(-1, nA, nB);
    chk("cw.doneA", busyA, 1'b0);
    rdChk("cw.rd5", 6'd5, 16'h0000, 16'h00AA);
    rdChk("cw.rd0", 6'd0, 16'h0000, 16'h00AA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
